// File: rtl/rename_map_unit.sv
// Register rename stage: alias table plus circular free list, reclaimed from commit.
// Define RENAME_CHECKPOINT_EN to add a single RAT/head snapshot with restore.

module rename_map_unit #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 128,
   parameter int PAYLOAD_W = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_i,
   output logic                           ready_i,
   input  logic [$clog2(ARCH_REGS)-1:0]   rs1_i,
   input  logic [$clog2(ARCH_REGS)-1:0]   rs2_i,
   input  logic [$clog2(ARCH_REGS)-1:0]   rd_i,
   input  logic                           rd_we_i,
   input  logic [PAYLOAD_W-1:0]           payload_i,
   output logic                           valid_o,
   input  logic                           ready_o,
   output logic [$clog2(PHYS_REGS)-1:0]   prs1_o,
   output logic [$clog2(PHYS_REGS)-1:0]   prs2_o,
   output logic [$clog2(PHYS_REGS)-1:0]   prd_o,
   output logic [$clog2(PHYS_REGS)-1:0]   old_prd_o,
   output logic [PAYLOAD_W-1:0]           payload_o,
   input  logic                           free_valid_i,
   input  logic [$clog2(PHYS_REGS)-1:0]   free_preg_i,
`ifdef RENAME_CHECKPOINT_EN
   input  logic                           ckpt_i,
   input  logic                           restore_i,
   output logic                           ckpt_valid_o,
`endif
   output logic [$clog2(PHYS_REGS):0]     free_count_o
);

   localparam int AW       = $clog2(ARCH_REGS);
   localparam int PW       = $clog2(PHYS_REGS);
   localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int FW       = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
   localparam int CW       = PW + 1;

   logic [PW-1:0]        rat_r [ARCH_REGS];
   logic [PW-1:0]        fl_r  [FL_DEPTH];
   logic [FW-1:0]        head_r, tail_r, head_inc_s, tail_inc_s, tail_nxt_s;
   logic [CW-1:0]        count_r, count_nxt_s;
   logic                 needs_alloc_s, accept_s, alloc_s, free_req_s, free_s, fl_full_s, restore_s;
   logic [PW-1:0]        alloc_preg_s;
   logic                 valid_r;
   logic [PW-1:0]        prs1_r, prs2_r, prd_r, old_prd_r;
   logic [PAYLOAD_W-1:0] payload_r;

`ifdef RENAME_CHECKPOINT_EN
   logic [PW-1:0]        ckpt_rat_r [ARCH_REGS];
   logic [FW-1:0]        ckpt_head_r;
   logic                 ckpt_full_r, ckpt_valid_r;
   logic [CW-1:0]        restore_count_s;

   assign restore_s    = restore_i && ckpt_valid_r;
   assign ckpt_valid_o = ckpt_valid_r;
`else
   assign restore_s    = 1'b0;
`endif

   // Handshake, allocate/free qualification and pointer/count arithmetic.
   always_comb begin
      needs_alloc_s = rd_we_i && (rd_i != {AW{1'b0}});
      fl_full_s     = (count_r == CW'(FL_DEPTH));
      // The freed register is not visible to allocation until it is registered.
      ready_i       = (!valid_r || ready_o) && !(needs_alloc_s && (count_r == {CW{1'b0}})) && !restore_s;
      accept_s      = valid_i && ready_i;
      alloc_s       = accept_s && needs_alloc_s;
      free_req_s    = free_valid_i && (free_preg_i != {PW{1'b0}});
      free_s        = free_req_s && !fl_full_s;
      alloc_preg_s  = fl_r[head_r];
      head_inc_s    = (head_r == FW'(FL_DEPTH - 1)) ? {FW{1'b0}} : head_r + FW'(1);
      tail_inc_s    = (tail_r == FW'(FL_DEPTH - 1)) ? {FW{1'b0}} : tail_r + FW'(1);
      tail_nxt_s    = free_s ? tail_inc_s : tail_r;
      if (alloc_s && !free_s) begin
         count_nxt_s = count_r - CW'(1);
      end else if (free_s && !alloc_s) begin
         count_nxt_s = count_r + CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

`ifdef RENAME_CHECKPOINT_EN
   // Occupancy after restore: equal pointers are ambiguous, resolved by the snapshot's full flag.
   always_comb begin
      if (tail_nxt_s == ckpt_head_r) begin
         restore_count_s = ckpt_full_r ? CW'(FL_DEPTH) : {CW{1'b0}};
      end else if (tail_nxt_s > ckpt_head_r) begin
         restore_count_s = CW'(tail_nxt_s) - CW'(ckpt_head_r);
      end else begin
         restore_count_s = CW'(FL_DEPTH) - CW'(ckpt_head_r) + CW'(tail_nxt_s);
      end
   end

   // Snapshot holds the RAT as it stands after the checkpointing instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         ckpt_valid_r <= 1'b0;
         ckpt_head_r  <= {FW{1'b0}};
         ckpt_full_r  <= 1'b0;
         for (int a = 0; a < ARCH_REGS; a++) begin
            ckpt_rat_r[a] <= PW'(a);
         end
      end else if (restore_s) begin
         ckpt_valid_r <= 1'b0;
      end else if (accept_s && ckpt_i) begin
         ckpt_valid_r <= 1'b1;
         ckpt_rat_r   <= rat_r;
         if (alloc_s) begin
            ckpt_rat_r[rd_i] <= alloc_preg_s;
         end
         ckpt_head_r  <= alloc_s ? head_inc_s : head_r;
         ckpt_full_r  <= (count_nxt_s == CW'(FL_DEPTH));
      end
   end
`endif

   // Free-list head, tail and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {FW{1'b0}};
         tail_r  <= {FW{1'b0}};
         count_r <= CW'(FL_DEPTH);
`ifdef RENAME_CHECKPOINT_EN
      end else if (restore_s) begin
         head_r  <= ckpt_head_r;
         tail_r  <= tail_nxt_s;
         count_r <= restore_count_s;
`endif
      end else begin
         if (alloc_s) begin
            head_r <= head_inc_s;
         end
         tail_r  <= tail_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // Free-list storage; starts as the registers not covered by the identity map.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            fl_r[i] <= PW'(ARCH_REGS + i);
         end
      end else if (free_s) begin
         fl_r[tail_r] <= free_preg_i;
      end
   end

   // Register alias table; x0 is never written since it never allocates.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < ARCH_REGS; a++) begin
            rat_r[a] <= PW'(a);
         end
`ifdef RENAME_CHECKPOINT_EN
      end else if (restore_s) begin
         rat_r <= ckpt_rat_r;
`endif
      end else if (alloc_s) begin
         rat_r[rd_i] <= alloc_preg_s;
      end
   end

   // Output stage; sources read the pre-update RAT so rs == rd sees the old mapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r   <= 1'b0;
         prs1_r    <= {PW{1'b0}};
         prs2_r    <= {PW{1'b0}};
         prd_r     <= {PW{1'b0}};
         old_prd_r <= {PW{1'b0}};
         payload_r <= {PAYLOAD_W{1'b0}};
      end else if (restore_s) begin
         valid_r   <= 1'b0;
      end else if (accept_s) begin
         valid_r   <= 1'b1;
         prs1_r    <= rat_r[rs1_i];
         prs2_r    <= rat_r[rs2_i];
         prd_r     <= needs_alloc_s ? alloc_preg_s : {PW{1'b0}};
         old_prd_r <= needs_alloc_s ? rat_r[rd_i] : {PW{1'b0}};
         payload_r <= payload_i;
      end else if (ready_o) begin
         valid_r   <= 1'b0;
      end
   end

   assign valid_o      = valid_r;
   assign prs1_o       = prs1_r;
   assign prs2_o       = prs2_r;
   assign prd_o        = prd_r;
   assign old_prd_o    = old_prd_r;
   assign payload_o    = payload_r;
   assign free_count_o = count_r;

`ifndef SYNTHESIS
   rename_map_unit_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .free_req (free_req_s),
      .fl_full  (fl_full_s)
   );
`endif

endmodule

`ifndef SYNTHESIS
// Simulation-only checker: a commit free into a full free list is a protocol error.
module rename_map_unit_chk (
   input logic clk,
   input logic reset,
   input logic free_req,
   input logic fl_full
);
   // Flag any free request that arrives while the list is full.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(free_req && fl_full))
         else $error("rename_map_unit: free request while free list is full");
      end
   end
endmodule
`endif

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: vector table, directed corner sequences and a
// randomized run against a queue/array reference model.

module tb_rename_map_unit;

   localparam int AR  = 32;
   localparam int PR  = 128;
   localparam int PLW = 64;
   localparam int FLD = PR - AR;

   logic          clk = 1'b0;
   logic          reset, valid_i, ready_i, rd_we_i, valid_o, ready_o, free_valid_i;
   logic [4:0]    rs1_i, rs2_i, rd_i;
   logic [63:0]   payload_i, payload_o;
   logic [6:0]    prs1_o, prs2_o, prd_o, old_prd_o, free_preg_i;
   logic [7:0]    free_count_o;
`ifdef RENAME_CHECKPOINT_EN
   logic          ckpt_i = 1'b0, restore_i = 1'b0, ckpt_valid_o;
`endif

   always #5 clk = ~clk;

   rename_map_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR), .PAYLOAD_W(PLW)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_i      (valid_i),
      .ready_i      (ready_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .rd_i         (rd_i),
      .rd_we_i      (rd_we_i),
      .payload_i    (payload_i),
      .valid_o      (valid_o),
      .ready_o      (ready_o),
      .prs1_o       (prs1_o),
      .prs2_o       (prs2_o),
      .prd_o        (prd_o),
      .old_prd_o    (old_prd_o),
      .payload_o    (payload_o),
      .free_valid_i (free_valid_i),
      .free_preg_i  (free_preg_i),
`ifdef RENAME_CHECKPOINT_EN
      .ckpt_i       (ckpt_i),
      .restore_i    (restore_i),
      .ckpt_valid_o (ckpt_valid_o),
`endif
      .free_count_o (free_count_o)
   );

   typedef struct {
      logic        rst, vld;
      logic [4:0]  rs1, rs2, rd;
      logic        we, rdy, fv;
      logic [6:0]  fp;
      logic [63:0] pay;
   } in_t;

   typedef struct {
      in_t i;
      logic e_rdy, e_vld;
      int   e_prs1, e_prs2, e_prd, e_old, e_cnt;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural map as an array, free list as a FIFO queue.
   int          m_rat[AR];
   int          m_fl[$];
   bit          m_vld;
   int          m_prs1, m_prs2, m_prd, m_old;
   logic [63:0] m_pay;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int a = 0; a < AR; a++) m_rat[a] = a;
      m_fl.delete();
      for (int i = 0; i < FLD; i++) m_fl.push_back(AR + i);
      m_vld = 1'b0; m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0; m_pay = 64'd0;
   endfunction

   function automatic in_t mk(logic rst, logic vld, int rs1, int rs2, int rd, logic we,
                              logic rdy, logic fv, int fp, logic [63:0] pay);
      in_t v;
      v.rst = rst; v.vld = vld; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
      v.we = we; v.rdy = rdy; v.fv = fv; v.fp = 7'(fp); v.pay = pay;
      return v;
   endfunction

   task automatic apply(input in_t v);
      reset = v.rst; valid_i = v.vld; rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
      rd_we_i = v.we; ready_o = v.rdy; free_valid_i = v.fv; free_preg_i = v.fp; payload_i = v.pay;
   endtask

   // One clock: drive at posedge+1, compare against the model at negedge, advance the model.
   task automatic do_cycle(input in_t v, output logic got_rdy);
      bit needs, mrdy, acc, fok;
      int p;
      apply(v);
      @(negedge clk);
      got_rdy = ready_i;
      needs = v.we && (v.rd != 5'd0);
      mrdy  = (!m_vld || v.rdy) && !(needs && m_fl.size() == 0);
      acc   = v.vld && mrdy;
      fok   = v.fv && (v.fp != 7'd0) && (m_fl.size() < FLD);
      if (!v.rst) check("ready_i", ready_i, mrdy);
      check("valid_o", valid_o, m_vld);
      check("free_count_o", free_count_o, m_fl.size());
      if (m_vld) begin
         check("prs1_o", prs1_o, m_prs1);
         check("prs2_o", prs2_o, m_prs2);
         check("prd_o", prd_o, m_prd);
         check("old_prd_o", old_prd_o, m_old);
         check("payload_o", payload_o, m_pay);
      end
      @(posedge clk);
      #1;
      if (v.rst) begin
         model_reset();
      end else begin
         if (acc) begin
            m_prs1 = m_rat[v.rs1];
            m_prs2 = m_rat[v.rs2];
            if (needs) begin
               p = m_fl.pop_front();
               m_old = m_rat[v.rd];
               m_prd = p;
               m_rat[v.rd] = p;
            end else begin
               m_prd = 0;
               m_old = 0;
            end
            m_pay = v.pay;
            m_vld = 1'b1;
         end else if (v.rdy) begin
            m_vld = 1'b0;
         end
         if (fok) m_fl.push_back(v.fp);
      end
   endtask

   task automatic do_reset();
      logic r;
      do_cycle(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0), r);
      do_cycle(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0), r);
   endtask

   initial begin
      vec_t tbl[9];
      logic r;
      in_t  v;
      logic [6:0]  hold_prd;
      logic [63:0] hold_pay;

      //                 rst vld rs1 rs2 rd we rdy fv fp  pay                 rdy vld prs1 prs2 prd old cnt
      tbl[0] = '{mk(0, 1, 1, 2, 5, 1, 1, 0, 0, 64'h100), 1'b1, 1'b1, 1, 2, 32, 5, 95};
      tbl[1] = '{mk(0, 1, 5, 0, 6, 1, 1, 0, 0, 64'h101), 1'b1, 1'b1, 32, 0, 33, 6, 94};
      tbl[2] = '{mk(0, 1, 6, 5, 5, 1, 1, 0, 0, 64'h102), 1'b1, 1'b1, 33, 32, 34, 32, 93};
      tbl[3] = '{mk(0, 1, 5, 6, 5, 1, 1, 0, 0, 64'h103), 1'b1, 1'b1, 34, 33, 35, 34, 92};
      tbl[4] = '{mk(0, 1, 6, 0, 0, 1, 1, 0, 0, 64'h104), 1'b1, 1'b1, 33, 0, 0, 0, 92};
      tbl[5] = '{mk(0, 1, 0, 5, 7, 0, 1, 0, 0, 64'h105), 1'b1, 1'b1, 0, 35, 0, 0, 92};
      tbl[6] = '{mk(0, 1, 3, 7, 3, 1, 1, 1, 50, 64'h106), 1'b1, 1'b1, 3, 7, 36, 3, 92};
      tbl[7] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 64'h107), 1'b1, 1'b0, 0, 0, 0, 0, 92};
      tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 60, 64'h108), 1'b1, 1'b0, 0, 0, 0, 0, 93};

      // Reset state
      apply(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0));
      @(posedge clk);
      #1;
      model_reset();
      do_cycle(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0), r);
      check("rst_valid_o", valid_o, 0);
      check("rst_prd_o", prd_o, 0);
      check("rst_old_prd_o", old_prd_o, 0);
      check("rst_prs1_o", prs1_o, 0);
      check("rst_payload_o", payload_o, 0);
      check("rst_free_count", free_count_o, FLD);

      // Vector table
      for (int k = 0; k < 9; k++) begin
         do_cycle(tbl[k].i, r);
         check("tbl_ready", r, tbl[k].e_rdy);
         check("tbl_valid", valid_o, tbl[k].e_vld);
         check("tbl_count", free_count_o, tbl[k].e_cnt);
         if (tbl[k].e_vld) begin
            check("tbl_prs1", prs1_o, tbl[k].e_prs1);
            check("tbl_prs2", prs2_o, tbl[k].e_prs2);
            check("tbl_prd", prd_o, tbl[k].e_prd);
            check("tbl_old", old_prd_o, tbl[k].e_old);
            check("tbl_payload", payload_o, tbl[k].i.pay);
         end
      end

      // Exhaust the free list, then a same-cycle free must not unblock
      do_reset();
      for (int k = 0; k < FLD; k++) begin
         do_cycle(mk(0, 1, k % 32, (k + 3) % 32, (k % 31) + 1, 1, 1, 0, 0, 64'(k)), r);
      end
      check("exh_count", free_count_o, 0);
      do_cycle(mk(0, 1, 1, 2, 4, 1, 1, 1, 40, 64'hAA), r);
      check("exh_blocked", r, 0);
      check("exh_count_after_free", free_count_o, 1);
      do_cycle(mk(0, 1, 1, 2, 4, 1, 1, 0, 0, 64'hAA), r);
      check("exh_unblocked", r, 1);
      check("exh_prd", prd_o, 40);
      check("exh_count_final", free_count_o, 0);

      // Backpressure hold
      do_reset();
      do_cycle(mk(0, 1, 1, 2, 9, 1, 1, 0, 0, 64'hBEEF), r);
      hold_prd = prd_o;
      hold_pay = payload_o;
      check("hold_first_prd", prd_o, 32);
      for (int k = 0; k < 4; k++) begin
         do_cycle(mk(0, 1, 3, 4, 10, 1, 0, 0, 0, 64'hCAFE), r);
         check("hold_ready", r, 0);
         check("hold_valid", valid_o, 1);
         check("hold_prd", prd_o, hold_prd);
         check("hold_payload", payload_o, hold_pay);
         check("hold_count", free_count_o, 95);
      end
      do_cycle(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0), r);
      check("hold_drain", valid_o, 0);

      // Randomized run against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         v.rst = ($urandom_range(0, 199) == 0);
         v.vld = ($urandom_range(0, 3) != 0);
         v.rs1 = 5'($urandom_range(0, 31));
         v.rs2 = 5'($urandom_range(0, 31));
         v.rd  = 5'($urandom_range(0, 31));
         v.we  = ($urandom_range(0, 3) != 0);
         v.rdy = ($urandom_range(0, 2) != 0);
         v.fv  = (m_fl.size() < FLD) && ($urandom_range(0, 2) == 0);
         v.fp  = 7'($urandom_range(0, 127));
         v.pay = {$urandom, $urandom};
         do_cycle(v, r);
      end

`ifdef RENAME_CHECKPOINT_EN
      // Checkpoint on rd=7, two more allocations, restore
      do_reset();
      ckpt_i = 1'b1;
      apply(mk(0, 1, 0, 0, 7, 1, 1, 0, 0, 64'd1));
      @(posedge clk); #1;
      ckpt_i = 1'b0;
      check("ckpt_valid", ckpt_valid_o, 1);
      check("ckpt_prd", prd_o, 32);
      apply(mk(0, 1, 0, 0, 8, 1, 1, 0, 0, 64'd2));
      @(posedge clk); #1;
      apply(mk(0, 1, 0, 0, 9, 1, 1, 0, 0, 64'd3));
      @(posedge clk); #1;
      check("ckpt_count_pre", free_count_o, 93);
      restore_i = 1'b1;
      apply(mk(0, 1, 0, 0, 10, 1, 1, 0, 0, 64'd4));
      @(negedge clk);
      check("restore_ready", ready_i, 0);
      @(posedge clk); #1;
      restore_i = 1'b0;
      check("restore_valid", valid_o, 0);
      check("restore_count", free_count_o, 95);
      check("restore_ckpt_valid", ckpt_valid_o, 0);
      apply(mk(0, 1, 7, 0, 11, 1, 1, 0, 0, 64'd5));
      @(posedge clk); #1;
      check("restore_prs1", prs1_o, 32);
      check("restore_prd", prd_o, 33);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rename_map_unit.md
Name: rename_map_unit

Overview:
- Parametrised successor to the single-issue register rename stage; sits between decode and dispatch/regbank.
- Maps architectural source and destination registers to physical registers through a register alias table (RAT) and a circular free list.
- Reclaims physical registers from the commit port.
- Emits the previous destination mapping so commit can free it later.

Parameters:
- ARCH_REGS, 32, number of architectural registers; x0 is never renamed.
- PHYS_REGS, 128, number of physical registers; must be greater than ARCH_REGS.
- PAYLOAD_W, 64, width of the opaque decoded-instruction payload passed through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  upstream instruction valid.
- ready_i  out  1  ready to upstream; accept when valid_i && ready_i.
- rs1_i, rs2_i, rd_i  in  $clog2(ARCH_REGS) each  architectural source and destination registers.
- rd_we_i  in  1  instruction writes rd.
- payload_i  in  PAYLOAD_W  passthrough payload.
- valid_o  out  1  output valid.
- ready_o  in  1  downstream ready; transfer when valid_o && ready_o.
- prs1_o, prs2_o, prd_o, old_prd_o  out  $clog2(PHYS_REGS) each  renamed sources, new destination, and previous destination mapping.
- payload_o  out  PAYLOAD_W  registered payload.
- free_valid_i  in  1  commit frees one physical register.
- free_preg_i  in  $clog2(PHYS_REGS)  physical register to free.
- free_count_o  out  $clog2(PHYS_REGS)+1  current free-list occupancy.

Behaviour:
- Reset:
  - RAT[a] = a for every architectural register a.
  - The free list holds ARCH_REGS..PHYS_REGS-1 in ascending order; head = 0, tail = 0, count = FL_DEPTH = PHYS_REGS-ARCH_REGS.
  - valid_o = 0. prs1_o, prs2_o, prd_o, old_prd_o and payload_o = 0. free_count_o = FL_DEPTH.
- Allocation need: needs_alloc = rd_we_i && (rd_i != 0).
- ready_i is combinational: (!valid_o || ready_o) && !(needs_alloc && count == 0).
- On accept, with one-cycle latency into the output register:
  - prs1_o = RAT[rs1_i] and prs2_o = RAT[rs2_i], read before this instruction's RAT write. rs == rd therefore yields the old mapping.
  - If needs_alloc: prd_o = free list[head]; old_prd_o = RAT[rd_i]; RAT[rd_i] <= prd_o; head increments, wrapping at FL_DEPTH; count decrements.
  - Otherwise prd_o = 0 and old_prd_o = 0, with no RAT or free-list change.
- Output register:
  - valid_o is set on accept.
  - valid_o is cleared on a transfer with no new accept.
  - Outputs are held stable while valid_o && !ready_o.
- Free port:
  - free_valid_i writes free_preg_i at tail; tail increments, wrapping; count increments.
  - free_preg_i == 0 is ignored.
  - Freeing when count == FL_DEPTH is illegal: ignored, and flagged by a simulation-only assertion.
- Simultaneous allocate and free: both happen; count is unchanged.
- No bypass from free to allocate: with count == 0, a same-cycle free does not unblock ready_i. The freed register becomes allocatable next cycle.
- free_count_o reflects the registered count.
- Reset asserted mid-operation: all state returns to reset values the next cycle. An in-flight output is dropped.

Optional Feature:
- Macro: RENAME_CHECKPOINT_EN.
- With the macro, three extra ports are added:
  - ckpt_i (in, 1): sampled on accept; snapshots the RAT after this instruction's update, plus the free-list head.
  - restore_i (in, 1): in the next cycle, RAT and head are restored from the snapshot; count = tail - head modulo FL_DEPTH, with full recomputed as head == tail && ckpt_full; valid_o is cleared; ready_i is forced 0 in the restore cycle.
  - ckpt_valid_o (out, 1): set by a snapshot, cleared by restore or reset. restore_i while ckpt_valid_o == 0 is ignored.
- Only one snapshot is held; a new ckpt_i overwrites it.
- Without the macro, the ports do not exist and there is no snapshot storage.

Test Plan:
- Reset then accept 3 instructions writing rd = 5, 6, 5 with ready_o = 1 -> prd_o = 32, 33, 34; old_prd_o = 5, 6, 32; free_count_o = 93.
- Instruction with rs1 = 5, rd = 5 after the sequence above -> prs1_o = 34 and prd_o = 35, in the same output beat.
- Write rd = 0 (x0) and instructions with rd_we_i = 0 -> prd_o = 0, old_prd_o = 0, free_count_o unchanged.
- Exhaust the free list (96 allocations), then present an allocating instruction -> ready_i = 0. Free preg 40 in that same cycle -> ready_i stays 0 that cycle; next cycle the instruction is accepted with prd_o = 40.
- Hold ready_o = 0 for 4 cycles with an instruction pending -> valid_o = 1, all outputs stable, ready_i = 0, no extra allocation. Simultaneous alloc plus free leaves the count constant.
- Under RENAME_CHECKPOINT_EN: checkpoint on rd = 7 -> 32, allocate 2 more, pulse restore_i -> next accepted rs1 = 7 reads 32, next prd_o = 33, free_count_o = 95.
